data_mem_ctrl: RTL

// Main data-memory controller directly downstream of the MEM-stage cache's memory port.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/data_mem_array.sv | 46 ++++
 rtl/data_mem_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane-order constants for the data-memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmc_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_BITS      = 8;

    // Big-endian lanes: lane 0 occupies bits 31:24, lane 3 bits 7:0.
    localparam int LANE_MSB_FIRST = 0;
    localparam int LANE_LSB_LAST  = BYTES_PER_WORD - 1;

    typedef logic [LANE_MSB_FIRST:LANE_LSB_LAST][LANE_BITS-1:0] word_t;

    localparam logic [LANE_MSB_FIRST:LANE_LSB_LAST] ALL_LANES = '1;

endpackage

// File: rtl/data_mem_array.sv
// Byte-lane word RAM: per-lane synchronous writes, registered read port.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:3]            we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [0:3][7:0]       wdata,
    output logic [0:3][7:0]       rdata
);

    word_t mem_q [2**ADDR_WIDTH];
    word_t rdata_q;
    word_t rdata_d;

    // Read register only moves on a read, so it holds the last read word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (we[i]) begin
                mem_q[addr][i] <= wdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Main data-memory controller: one block access per request, fixed latency,
// one-cycle response strobe and busy for pipeline stall logic.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [0:3][7:0] req_wdata,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [0:3][7:0] resp_rdata,
    output logic            busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmc_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    word_t                 wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  commit;
    logic [0:3]            mem_we;
    logic                  mem_re;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

    assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                    wr_d    = req_write;
                    idx_d   = req_addr[ADDR_WIDTH+1:2];
                    wdata_d = req_wdata;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d      = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Reset on the commit edge must win, so the RAM strobes are gated by rst.
    assign mem_we = (commit && wr_q && !rst) ? ALL_LANES : '0;
    assign mem_re = commit && !wr_q && !rst;

    data_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(resp_rdata)
    );

    assign req_ready  = ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;

endmodule
